// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad entry of M:ST, countdown on a 1 Hz tick,
// pause on stop or door open, and a one-cycle done pulse when the count finishes.
module microwave_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       door_closed,
   output logic [3:0] min,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       mag_on,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] min_q, min_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       magOn_q, magOn_d;
   logic       done_q, done_d;
   logic       timeIsZero;
   logic       timeIsOne;
   logic       finishing;

   assign timeIsZero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
   assign timeIsOne  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         min_q   <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         magOn_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         magOn_q <= magOn_d;
         done_q  <= done_d;
      end
   end

   // Events are tested in priority order so a higher event masks all lower ones.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      finishing = 1'b0;
      if (clear) begin
         state_d = IDLE;
         min_d   = 4'd0;
         tens_d  = 4'd0;
         ones_d  = 4'd0;
      end else if (stop) begin
         if (state_q == RUN) begin
            state_d = PAUSE;
         end else begin
            state_d = IDLE;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && door_closed && !timeIsZero) begin
                  state_d = RUN;
               end else if (digit_valid && (digit <= 4'd9)) begin
                  min_d  = tens_q;
                  tens_d = ones_q;
                  ones_d = digit;
               end
            end
            RUN: begin
               if (!door_closed) begin
                  state_d = PAUSE;
               end else if (tick_1hz) begin
                  if (ones_q != 4'd0) begin
                     ones_d = ones_q - 4'd1;
                  end else if (tens_q != 4'd0) begin
                     tens_d = tens_q - 4'd1;
                     ones_d = 4'd9;
                  end else begin
                     min_d  = min_q - 4'd1;
                     tens_d = 4'd5;
                     ones_d = 4'd9;
                  end
                  if (timeIsOne) begin
                     state_d   = IDLE;
                     finishing = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (start && door_closed) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      magOn_d = (state_d == RUN);
      done_d  = finishing;
   end

   assign min      = min_q;
   assign sec_tens = tens_q;
   assign sec_ones = ones_q;
   assign mag_on   = magOn_q;
   assign done     = done_q;

endmodule
